alu_req_scheduler: RTL
======================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one calculator_fsm ALU among N_REQ requesters. Arbitrates round-robin and
//  launches one operation at a time. Waits for the ALU done pulse, with a timeout.
//  Returns the result to the owning requester. Sits between requester blocks and the ALU.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  TIMEOUT  16  max WAIT cycles before aborting the op with an error (>=4)
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         asynchronous, active-high reset
//  req_valid     in   N_REQ     requester i has an op pending
//  req_ready     out  N_REQ     one-hot, 1-cycle accept pulse to the winning requester
//  req_op        in   4*N_REQ   op_sel per requester, slice [4i+3:4i]
//  req_a         in   16*N_REQ  operand A per requester
//  req_b         in   16*N_REQ  operand B per requester
//  resp_valid    out  N_REQ     one-hot, 1-cycle result pulse to the owner
//  resp_result   out  32        result; valid only while resp_valid!=0
//  resp_err      out  1         qualifies resp_valid: 1 = illegal op or timeout
//  alu_start     out  1         1-cycle launch pulse to the ALU
//  alu_op        out  4         op_sel to the ALU (held from ISSUE through WAIT)
//  alu_a, alu_b  out  16 each   operands to the ALU (held from ISSUE through WAIT)
//  alu_done      in   1         ALU completion pulse
//  alu_result    in   32        ALU result, sampled when alu_done=1 in WAIT
// BEHAVIOUR
//  Reset values: all outputs 0, state=IDLE, rr_ptr=0, owner=0, timer=0.
//   Reset mid-operation drops the in-flight op; no response is ever issued for it.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; ILLEGAL op: ISSUE -> RESP.
//  IDLE
//   - If any req_valid: winner = first set bit at or after rr_ptr, circular.
//   - Pulse req_ready[winner]; latch winner into owner; latch op/a/b; go to ISSUE.
//   - req_ready is asserted only in IDLE. Requesters hold valid/data until ready.
//  ISSUE
//   - op <= 4'hA: alu_start=1 for exactly 1 cycle, timer cleared, go to WAIT.
//   - op > 4'hA: no ALU launch; set err=1, result=0, go to RESP.
//  WAIT
//   - alu_done=1: capture alu_result, err=0, go to RESP.
//   - Else timer++. When timer reaches TIMEOUT-1 without done: err=1, result=0, go to RESP.
//   - Done and the timeout limit in the same cycle: done wins.
//  RESP
//   - resp_valid[owner]=1 for 1 cycle, with resp_result and resp_err.
//   - rr_ptr <= owner+1, wrapping N_REQ-1 -> 0. Go to IDLE.
//   - A req_valid present during RESP is not accepted until the following IDLE cycle.
//  Other rules
//   - alu_done outside WAIT is ignored.
//   - Timing: accept edge at t0 -> alu_start at t1 -> resp_valid at t4 (2-cycle ALU).
//     Max throughput is one op per 5 cycles.
//   - resp_result/resp_err hold their last value between responses; alu_* hold when idle.
//   - Fairness: a continuously requesting requester is served within N_REQ grants.
// STRUCTURE
//  Package alu_sched_pkg
//   - state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
//   - op codes OP_ADD..OP_ASR (4'h0..4'hA); OP_MAX=4'hA.
//  Sub-module rr_arbiter #(N)
//   - inputs: req, ptr. Output: one-hot grant (combinational). Reused by other shared units.
//  Top: FSM, operand/owner registers, timeout counter, response registers.
// TESTING
//  1. Reset mid-WAIT: raise reset on the cycle after alu_start.
//     -> all outputs 0 immediately; no resp_valid after release; next grant goes to req0.
//  2. Single op: req_valid=0001, op=0, a=3, b=5.
//     -> req_ready=0001 at t0; alu_start at t1; resp_valid=0001 at t4, result=8, err=0.
//  3. Round-robin: req_valid=1111 held, with rr_ptr starting at 0.
//     -> grants issued in order 0,1,2,3,0; each resp_valid goes to the matching owner.
//  4. Illegal op: req op=4'hC.
//     -> alu_start never asserts; resp_valid with err=1, result=0, at t2.
//  5. Timeout: ALU model never pulses done, TIMEOUT=16.
//     -> resp err=1 exactly 16 cycles after alu_start; FSM returns to IDLE; next request served.
//  6. Division: op=3, a=100, b=7 -> result=14. Then b=0 -> result=32'h0000FFFF, err=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_sched_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Operation codes understood by the shared calculator ALU.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_ROL = 4'h9,
    OP_ASR = 4'hA
  } alu_op_t;

  localparam logic [3:0] OP_MAX = 4'hA;

  // Codes above OP_MAX are rejected without ever reaching the ALU.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching circularly. Kept generic so other shared units can reuse it.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;

  // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    rot_req = N'({req, req} >> ptr);
    rot_gnt = rot_req & (~rot_req + {{(N-1){1'b0}}, 1'b1});
    grant   = N'(({rot_gnt, rot_gnt} << ptr) >> N);
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one calculator ALU among N_REQ requesters: round-robin accept,
// single op in flight, done-or-timeout wait, one-hot response to the owner.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | pick a winner, pulse its req_ready, latch owner/op/operands
//  ISSUE | legal op: pulse alu_start and arm timer; illegal: error response
//  WAIT  | wait for alu_done; abort with error when the timer expires
//  RESP  | pulse resp_valid to owner, advance round-robin pointer
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_op,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [31:0]           resp_result,
  output logic                  resp_err,
  output logic                  alu_start,
  output logic [3:0]            alu_op,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  input  logic                  alu_done,
  input  logic [31:0]           alu_result
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  // The timer counts down over the WAIT cycles; loading TIMEOUT-2 gives
  // TIMEOUT-1 WAIT cycles, so the error response lands TIMEOUT cycles
  // after alu_start.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 2);

  sched_state_t   state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [3:0]     op_q, op_d;
  logic [15:0]    a_q, a_d;
  logic [15:0]    b_q, b_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [31:0]    res_q, res_d;
  logic           err_q, err_d;

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Encode the one-hot grant into a requester index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // Next-state and next-register values; everything holds by default.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    timer_d  = timer_q;
    res_d    = res_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = grant_idx;
          op_d    = req_op[{grant_idx, 2'b00} +: 4];
          a_d     = req_a[{grant_idx, 4'b0000} +: 16];
          b_d     = req_b[{grant_idx, 4'b0000} +: 16];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_is_legal(op_q)) begin
          timer_d = TMR_LOAD;
          state_d = WAIT;
        end else begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        // A done arriving on the last allowed cycle still counts.
        if (alu_done) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RESP: begin
        rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
        state_d  = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pointer, owner, operand, timer and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      timer_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      timer_q  <= timer_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // Handshake pulses decoded from state; ready is masked during reset so
  // every output reads zero while reset is held.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state_q == IDLE && !reset) req_ready = grant;
    if (state_q == RESP) resp_valid[owner_q] = 1'b1;
    alu_start = (state_q == ISSUE) && op_is_legal(op_q);
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_result = res_q;
  assign resp_err    = err_q;

endmodule
